nv_nvdla_xvif_rd_ig_wrr_arb: RTL and testbench
==============================================

// Module: nv_nvdla_xvif_rd_ig_wrr_arb
// PURPOSE
// - Parametrised read-request ingress arbiter for the DMA-to-memory-interface read path.
// - Merges NUM_CLIENTS per-client read requests into one stream using weighted round-robin.
// - Gates new grants on a programmable outstanding-transaction limit and registers the winner.
// - Sits between the per-client bpt stages and the split/convert stages. Replaces the fixed 10-client arbiter.
// PARAMETERS
// - NUM_CLIENTS  10   number of request clients (2..16)
// - PD_W         75   request payload width
// - WT_W         8    per-client weight width
// - OS_W         8    outstanding-limit register width
// - ID_W         4    source-id width; must be >= clog2(NUM_CLIENTS)
// PORTS
// - nvdla_core_clk     in   1               core clock
// - nvdla_core_rst     in   1               synchronous reset, active-high
// - req_valid          in   NUM_CLIENTS     per-client request valid
// - req_ready          out  NUM_CLIENTS     per-client request accept
// - req_pd             in   NUM_CLIENTS*PD_W  payloads; client i at [i*PD_W +: PD_W]
// - reg2dp_rd_weight   in   NUM_CLIENTS*WT_W  per-client weights; quasi-static
// - reg2dp_rd_os_cnt   in   OS_W            outstanding limit; allows value+1 in flight
// - eg2ig_axi_vld      in   1               one pulse per completed read transaction
// - arb_req_valid      out  1               registered winner valid
// - arb_req_ready      in   1               downstream accept
// - arb_req_pd         out  PD_W            winner payload
// - arb_req_src_id     out  ID_W            winner client index
// - os_inflight        out  OS_W+1          current outstanding count
// BEHAVIOUR
// - Reset values:
//   - arb_req_valid=0, arb_req_pd=0, arb_req_src_id=0, os_inflight=0.
//   - RR pointer=0, burst counter=0.
//   - req_ready=0 during reset.
// - Output slot:
//   - One-entry output register. can_load = !arb_req_valid | arb_req_ready.
//   - Throughput is 1 request/cycle. Latency is 1 cycle from req handshake to arb_req_valid.
// - os_ok = (os_inflight <= reg2dp_rd_os_cnt).
// - Grant:
//   - Evaluated only when can_load & os_ok & |req_valid.
//   - Exactly one req_ready bit goes high, for the winner, in the same cycle (combinational from req_valid).
//   - req_ready is 0 for all other clients.
// - WRR:
//   - Current owner = client at RR pointer, if it is valid.
//   - It may take up to weight+1 consecutive grants. Weight 0 gives 1 grant per turn; no client is starved.
//   - The burst counter increments on each owner grant.
//   - The turn ends when the counter reaches the owner's weight, or when the owner drops valid.
//   - At turn end the pointer moves to the next valid client in ascending index order, wrapping NUM_CLIENTS-1 -> 0, and the counter clears.
//   - If the owner is not valid, the first valid client searching upward from pointer+1 wins.
//   - That winner becomes owner and its counter starts at 1.
// - Outstanding counter:
//   - +1 on each grant; -1 on each eg2ig_axi_vld. Simultaneous +1/-1 leaves it unchanged.
//   - Decrement at 0 is ignored (saturate).
//   - Increment cannot exceed reg2dp_rd_os_cnt+1, because grants are gated by os_ok.
// - Limit lowered below os_inflight: grants stall until completions drain the count. No flush.
// - Stall hold: arb_req_valid=1 & !arb_req_ready keeps pd and src_id stable, and no grant is made.
// - Reset mid-operation:
//   - The held output is dropped and the counters clear.
//   - Responses for pre-reset requests are not tracked. Clients must reset together with this block.
// - With NUM_CLIENTS=1 the block degenerates to a registered pass-through with os gating.
// CONFIGURATION
// - NV_NVDLA_XVIF_RD_IG_STALL_STAT_EN defined:
//   - Adds output os_stall_cnt[31:0], reset 0.
//   - It increments each cycle that |req_valid & can_load & !os_ok, and saturates at 32'hFFFFFFFF.
// - Undefined: the port and the counter are absent. All other behaviour is identical.
// TESTING
// - Weights all 0, clients 0,1,2 valid continuously, ready=1, os_cnt=255 -> grant order 0,1,2,0,1,2; one per cycle.
// - weight[0]=2, weight[1]=0, both valid continuously -> pattern 0,0,0,1 repeating; arb_req_src_id matches.
// - os_cnt=1, no eg2ig_axi_vld -> exactly 2 grants, then req_ready=0. One eg2ig_axi_vld pulse -> exactly 1 more grant.
// - Same cycle grant + eg2ig_axi_vld at os_inflight=2 -> stays 2. eg2ig_axi_vld at 0 -> stays 0.
// - arb_req_ready held 0 for 5 cycles with a winner loaded -> pd/src_id stable, all req_ready=0. Then ready=1 -> next grant the same cycle.
// - Only client NUM_CLIENTS-1 valid and pointer at NUM_CLIENTS-1 with turn ended, then client 0 valid -> wrap grants client 0.
// - Reset asserted while arb_req_valid=1 and os_inflight=3 -> next cycle arb_req_valid=0, os_inflight=0.
// - STALL_STAT_EN: os gating blocks a valid request for 7 cycles -> os_stall_cnt=7.

Source files
------------

// File: rtl/nv_nvdla_xvif_rd_ig_wrr_arb.sv
// Weighted round-robin read-request ingress arbiter with outstanding-transaction gating and a registered output slot.
// Optional stall statistics counter (os_stall_cnt) is built when NV_NVDLA_XVIF_RD_IG_STALL_STAT_EN is defined.
module nv_nvdla_xvif_rd_ig_wrr_arb #(
    parameter int NUM_CLIENTS = 10,
    parameter int PD_W        = 75,
    parameter int WT_W        = 8,
    parameter int OS_W        = 8,
    parameter int ID_W        = 4
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rst,
    input  logic [NUM_CLIENTS-1:0]      req_valid,
    output logic [NUM_CLIENTS-1:0]      req_ready,
    input  logic [NUM_CLIENTS*PD_W-1:0] req_pd,
    input  logic [NUM_CLIENTS*WT_W-1:0] reg2dp_rd_weight,
    input  logic [OS_W-1:0]             reg2dp_rd_os_cnt,
    input  logic                        eg2ig_axi_vld,
    output logic                        arb_req_valid,
    input  logic                        arb_req_ready,
    output logic [PD_W-1:0]             arb_req_pd,
    output logic [ID_W-1:0]             arb_req_src_id,
    output logic [OS_W:0]               os_inflight
`ifdef NV_NVDLA_XVIF_RD_IG_STALL_STAT_EN
    ,
    output logic [31:0]                 os_stall_cnt
`endif
);

    // First valid client strictly after base in ascending, wrapping order; base itself is the last candidate.
    function automatic logic [ID_W-1:0] next_valid(input logic [NUM_CLIENTS-1:0] vld,
                                                   input logic [ID_W-1:0]        base);
        int best;
        int d;
        next_valid = base;
        best       = NUM_CLIENTS;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            d = i - int'(base) - 1;
            if (d < 0) d = d + NUM_CLIENTS;
            if (vld[i] && d < best) begin
                best       = d;
                next_valid = ID_W'(i);
            end
        end
    endfunction

    logic [ID_W-1:0] rr_ptr;
    logic [WT_W-1:0] burst_cnt;

    logic            can_load;
    logic            os_ok;
    logic            grant;
    logic            owner_vld;
    logic [ID_W-1:0] win_idx;
    logic [WT_W-1:0] win_wt;
    logic [PD_W-1:0] win_pd;
    logic [WT_W:0]   taken;
    logic            turn_end;
    logic [ID_W-1:0] nxt_ptr;
    logic [WT_W-1:0] nxt_cnt;
    logic            os_dec;

    assign can_load = !arb_req_valid || arb_req_ready;
    assign os_ok    = os_inflight <= {1'b0, reg2dp_rd_os_cnt};
    assign grant    = can_load && os_ok && (|req_valid) && !nvdla_core_rst;
    assign os_dec   = eg2ig_axi_vld && (os_inflight != '0);

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        owner_vld = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (rr_ptr == ID_W'(i)) owner_vld = req_valid[i];
        end

        win_idx = owner_vld ? rr_ptr : next_valid(req_valid, rr_ptr);

        win_wt = '0;
        win_pd = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_wt = reg2dp_rd_weight[i*WT_W +: WT_W];
                win_pd = req_pd[i*PD_W +: PD_W];
            end
        end

        // A continuing owner adds to its burst; a newly found winner has used one grant.
        taken    = owner_vld ? ({1'b0, burst_cnt} + 1'b1) : {{WT_W{1'b0}}, 1'b1};
        turn_end = taken > {1'b0, win_wt};
        nxt_ptr  = turn_end ? next_valid(req_valid, win_idx) : win_idx;
        nxt_cnt  = turn_end ? '0 : taken[WT_W-1:0];

        req_ready = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            req_ready[i] = grant && (win_idx == ID_W'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            rr_ptr         <= '0;
            burst_cnt      <= '0;
            arb_req_valid  <= 1'b0;
            arb_req_pd     <= '0;
            arb_req_src_id <= '0;
            os_inflight    <= '0;
        end else begin
            if (grant) begin
                rr_ptr    <= nxt_ptr;
                burst_cnt <= nxt_cnt;
            end

            if (can_load) begin
                arb_req_valid <= grant;
                if (grant) begin
                    arb_req_pd     <= win_pd;
                    arb_req_src_id <= win_idx;
                end
            end

            // Grant and completion in the same cycle cancel out.
            if (grant && !os_dec) begin
                os_inflight <= os_inflight + 1'b1;
            end else if (!grant && os_dec) begin
                os_inflight <= os_inflight - 1'b1;
            end
        end
    end

`ifdef NV_NVDLA_XVIF_RD_IG_STALL_STAT_EN
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            os_stall_cnt <= '0;
        end else if ((|req_valid) && can_load && !os_ok && (os_stall_cnt != 32'hFFFF_FFFF)) begin
            os_stall_cnt <= os_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nv_nvdla_xvif_rd_ig_wrr_arb.sv
// Self-checking bench for nv_nvdla_xvif_rd_ig_wrr_arb: vector table, directed corner sequences and
// randomized traffic compared against a grant-level reference model.
module tb_nv_nvdla_xvif_rd_ig_wrr_arb;

    localparam int N    = 10;
    localparam int PD_W = 75;
    localparam int WT_W = 8;
    localparam int OS_W = 8;
    localparam int ID_W = 4;

    logic                clk = 1'b0;
    logic                nvdla_core_rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*PD_W-1:0]   req_pd;
    logic [N*WT_W-1:0]   reg2dp_rd_weight;
    logic [OS_W-1:0]     reg2dp_rd_os_cnt;
    logic                eg2ig_axi_vld;
    logic                arb_req_valid;
    logic                arb_req_ready;
    logic [PD_W-1:0]     arb_req_pd;
    logic [ID_W-1:0]     arb_req_src_id;
    logic [OS_W:0]       os_inflight;
`ifdef NV_NVDLA_XVIF_RD_IG_STALL_STAT_EN
    logic [31:0]         os_stall_cnt;
`endif

    always #5 clk = ~clk;

    nv_nvdla_xvif_rd_ig_wrr_arb #(
        .NUM_CLIENTS(N), .PD_W(PD_W), .WT_W(WT_W), .OS_W(OS_W), .ID_W(ID_W)
    ) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rst   (nvdla_core_rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_pd           (req_pd),
        .reg2dp_rd_weight (reg2dp_rd_weight),
        .reg2dp_rd_os_cnt (reg2dp_rd_os_cnt),
        .eg2ig_axi_vld    (eg2ig_axi_vld),
        .arb_req_valid    (arb_req_valid),
        .arb_req_ready    (arb_req_ready),
        .arb_req_pd       (arb_req_pd),
        .arb_req_src_id   (arb_req_src_id),
        .os_inflight      (os_inflight)
`ifdef NV_NVDLA_XVIF_RD_IG_STALL_STAT_EN
        ,
        .os_stall_cnt     (os_stall_cnt)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else             n_pass++;
    endtask

    // ---------------- configuration ----------------
    int weight[N];
    int os_lim;

    task automatic set_cfg(input int w0, input int lim);
        for (int i = 0; i < N; i++) weight[i] = 0;
        weight[0] = w0;
        os_lim    = lim;
        for (int i = 0; i < N; i++) reg2dp_rd_weight[i*WT_W +: WT_W] = WT_W'(weight[i]);
        reg2dp_rd_os_cnt = OS_W'(os_lim);
    endtask

    // ---------------- reference model ----------------
    int             m_ptr, m_cnt, m_os, m_src;
    bit             m_valid;
    logic [PD_W-1:0] m_pd;
    longint         m_stall;

    bit           e_grant, e_can_load, e_stall_inc;
    int           e_win, e_ptr_n, e_cnt_n;
    logic [N-1:0] e_ready;

    function automatic int first_after(input int p);
        int idx;
        first_after = p;
        for (int k = N; k >= 1; k--) begin
            idx = (p + k) % N;
            if (req_valid[idx]) first_after = idx;
        end
    endfunction

    task automatic model_eval();
        int taken;
        bit os_ok;
        e_ready     = '0;
        e_grant     = 1'b0;
        e_win       = 0;
        e_ptr_n     = m_ptr;
        e_cnt_n     = m_cnt;
        e_can_load  = !m_valid || arb_req_ready;
        os_ok       = m_os <= os_lim;
        e_stall_inc = (req_valid != '0) && e_can_load && !os_ok;
        if (!nvdla_core_rst && e_can_load && os_ok && req_valid != '0) begin
            e_grant = 1'b1;
            if (req_valid[m_ptr]) begin
                e_win = m_ptr;
                taken = m_cnt + 1;
            end else begin
                e_win = first_after(m_ptr);
                taken = 1;
            end
            if (taken > weight[e_win]) begin
                e_ptr_n = first_after(e_win);
                e_cnt_n = 0;
            end else begin
                e_ptr_n = e_win;
                e_cnt_n = taken;
            end
            e_ready[e_win] = 1'b1;
        end
    endtask

    task automatic model_commit();
        bit dec;
        if (nvdla_core_rst) begin
            m_ptr = 0; m_cnt = 0; m_os = 0; m_src = 0;
            m_valid = 1'b0; m_pd = '0; m_stall = 0;
        end else begin
            dec = eg2ig_axi_vld && m_os > 0;
            if (e_grant) begin
                m_ptr = e_ptr_n;
                m_cnt = e_cnt_n;
            end
            if (e_grant && !dec)      m_os++;
            else if (!e_grant && dec) m_os--;
            if (e_can_load) begin
                m_valid = e_grant;
                if (e_grant) begin
                    m_pd  = req_pd[e_win*PD_W +: PD_W];
                    m_src = e_win;
                end
            end
            if (e_stall_inc && m_stall < 64'hFFFF_FFFF) m_stall++;
        end
    endtask

    // ---------------- cycle helpers ----------------
    // NOTE: inputs are driven with blocking assignments just after the falling edge, well clear of the sampling edge.
    task automatic apply(input bit r, input logic [N-1:0] v, input bit a, input bit e);
        logic [95:0] t;
        nvdla_core_rst = r;
        req_valid      = v;
        arb_req_ready  = a;
        eg2ig_axi_vld  = e;
        for (int i = 0; i < N; i++) begin
            t = {$urandom(), $urandom(), $urandom()};
            req_pd[i*PD_W +: PD_W] = t[PD_W-1:0];
        end
        #1;
        model_eval();
    endtask

    task automatic check_model();
        check("m_req_ready", req_ready, e_ready);
        check("m_arb_req_valid", arb_req_valid, m_valid);
        if (m_valid) begin
            check("m_arb_req_pd", arb_req_pd, m_pd);
            check("m_arb_req_src_id", arb_req_src_id, m_src);
        end
        check("m_os_inflight", os_inflight, m_os);
`ifdef NV_NVDLA_XVIF_RD_IG_STALL_STAT_EN
        check("m_os_stall_cnt", os_stall_cnt, m_stall);
`endif
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input bit r, input logic [N-1:0] v, input bit a, input bit e);
        apply(r, v, a, e);
        check_model();
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit           rst;
        logic [N-1:0] v;
        bit           a;
        bit           e;
        int           w0;
        int           lim;
        logic [N-1:0] x_ready;
        bit           x_valid;
        int           x_src;
        int           x_os;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input bit r, input logic [N-1:0] v, input bit a, input bit e, input int w0,
                       input int lim, input logic [N-1:0] xr, input bit xv, input int xs, input int xo);
        vec_t t;
        t.rst = r; t.v = v; t.a = a; t.e = e; t.w0 = w0; t.lim = lim;
        t.x_ready = xr; t.x_valid = xv; t.x_src = xs; t.x_os = xo;
        tbl.push_back(t);
    endtask

    logic [PD_W-1:0] held_pd;

    initial begin
        nvdla_core_rst = 1'b1;
        req_valid      = '0;
        arb_req_ready  = 1'b0;
        eg2ig_axi_vld  = 1'b0;
        req_pd         = '0;
        set_cfg(0, 255);
        m_ptr = 0; m_cnt = 0; m_os = 0; m_src = 0; m_valid = 1'b0; m_pd = '0; m_stall = 0;
        @(negedge clk);

        // Reset state, with every client requesting during reset.
        apply(1, '1, 1, 0);
        check("rst_req_ready", req_ready, '0);
        tick();
        apply(0, '0, 1, 0);
        check("rst_arb_req_valid", arb_req_valid, 1'b0);
        check("rst_arb_req_pd", arb_req_pd, '0);
        check("rst_arb_req_src_id", arb_req_src_id, '0);
        check("rst_os_inflight", os_inflight, '0);
`ifdef NV_NVDLA_XVIF_RD_IG_STALL_STAT_EN
        check("rst_os_stall_cnt", os_stall_cnt, '0);
`endif
        tick();

        // Weights all 0, clients 0..2: order 0,1,2,0,1,2.
        row(1, '1,     1, 0, 0, 255, '0,     0, 0, 0);
        row(0, 10'h007, 1, 0, 0, 255, 10'h001, 0, 0, 0);
        row(0, 10'h007, 1, 0, 0, 255, 10'h002, 1, 0, 1);
        row(0, 10'h007, 1, 0, 0, 255, 10'h004, 1, 1, 2);
        row(0, 10'h007, 1, 0, 0, 255, 10'h001, 1, 2, 3);
        row(0, 10'h007, 1, 0, 0, 255, 10'h002, 1, 0, 4);
        row(0, 10'h007, 1, 0, 0, 255, 10'h004, 1, 1, 5);
        row(0, 10'h000, 1, 0, 0, 255, 10'h000, 1, 2, 6);
        // weight[0]=2, weight[1]=0: 0,0,0,1 repeating.
        row(1, '1,     1, 0, 2, 255, '0,     0, 0, 0);
        row(0, 10'h003, 1, 0, 2, 255, 10'h001, 0, 0, 0);
        row(0, 10'h003, 1, 0, 2, 255, 10'h001, 1, 0, 1);
        row(0, 10'h003, 1, 0, 2, 255, 10'h001, 1, 0, 2);
        row(0, 10'h003, 1, 0, 2, 255, 10'h002, 1, 0, 3);
        row(0, 10'h003, 1, 0, 2, 255, 10'h001, 1, 1, 4);
        row(0, 10'h003, 1, 0, 2, 255, 10'h001, 1, 0, 5);
        row(0, 10'h003, 1, 0, 2, 255, 10'h001, 1, 0, 6);
        row(0, 10'h003, 1, 0, 2, 255, 10'h002, 1, 0, 7);
        row(0, 10'h000, 1, 0, 2, 255, 10'h000, 1, 1, 8);
        // os_cnt=1: two grants, stall, one completion frees exactly one more.
        row(1, '1,     1, 0, 0, 1, '0,     0, 0, 0);
        row(0, 10'h008, 1, 0, 0, 1, 10'h008, 0, 0, 0);
        row(0, 10'h008, 1, 0, 0, 1, 10'h008, 1, 3, 1);
        row(0, 10'h008, 1, 0, 0, 1, 10'h000, 1, 3, 2);
        row(0, 10'h008, 1, 0, 0, 1, 10'h000, 0, 0, 2);
        row(0, 10'h008, 1, 1, 0, 1, 10'h000, 0, 0, 2);
        row(0, 10'h008, 1, 0, 0, 1, 10'h008, 0, 0, 1);
        row(0, 10'h008, 1, 0, 0, 1, 10'h000, 1, 3, 2);
        row(0, 10'h008, 1, 0, 0, 1, 10'h000, 0, 0, 2);
        // Grant + completion at 2 holds 2; completion at 0 saturates.
        row(1, '1,     1, 0, 0, 255, '0,     0, 0, 0);
        row(0, 10'h001, 1, 0, 0, 255, 10'h001, 0, 0, 0);
        row(0, 10'h001, 1, 0, 0, 255, 10'h001, 1, 0, 1);
        row(0, 10'h001, 1, 1, 0, 255, 10'h001, 1, 0, 2);
        row(0, 10'h000, 1, 0, 0, 255, 10'h000, 1, 0, 2);
        row(0, 10'h000, 1, 1, 0, 255, 10'h000, 0, 0, 2);
        row(0, 10'h000, 1, 1, 0, 255, 10'h000, 0, 0, 1);
        row(0, 10'h000, 1, 1, 0, 255, 10'h000, 0, 0, 0);
        row(0, 10'h000, 1, 0, 0, 255, 10'h000, 0, 0, 0);

        foreach (tbl[i]) begin
            set_cfg(tbl[i].w0, tbl[i].lim);
            apply(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].e);
            check($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].x_ready);
            if (!tbl[i].rst) begin
                check($sformatf("tbl%0d_arb_req_valid", i), arb_req_valid, tbl[i].x_valid);
                if (tbl[i].x_valid) check($sformatf("tbl%0d_src_id", i), arb_req_src_id, tbl[i].x_src);
                check($sformatf("tbl%0d_os_inflight", i), os_inflight, tbl[i].x_os);
            end
            check_model();
            tick();
        end

        // Stall hold: winner loaded, downstream not ready for 5 cycles.
        set_cfg(0, 255);
        step(1, '0, 1, 0);
        apply(0, 10'h006, 1, 0);
        check("stall_first_ready", req_ready, 10'h002);
        held_pd = req_pd[1*PD_W +: PD_W];
        check_model();
        tick();
        for (int c = 0; c < 5; c++) begin
            apply(0, 10'h006, 0, 0);
            check("stall_req_ready", req_ready, '0);
            check("stall_pd", arb_req_pd, held_pd);
            check("stall_src_id", arb_req_src_id, 1);
            check_model();
            tick();
        end
        apply(0, 10'h006, 1, 0);
        check("stall_release_ready", req_ready, 10'h004);
        check_model();
        tick();

        // Wrap: only client N-1 requests, its turn ends, then client 0 requests.
        step(1, '0, 1, 0);
        step(0, 10'h200, 1, 0);
        step(0, 10'h200, 1, 0);
        apply(0, 10'h001, 1, 0);
        check("wrap_req_ready", req_ready, 10'h001);
        check_model();
        tick();
        apply(0, '0, 1, 0);
        check("wrap_src_id", arb_req_src_id, 0);
        check_model();
        tick();

        // Reset while a winner is held and three requests are outstanding.
        step(1, '0, 1, 0);
        for (int c = 0; c < 3; c++) step(0, 10'h001, 1, 0);
        apply(0, '0, 0, 0);
        check("midrst_pre_valid", arb_req_valid, 1'b1);
        check("midrst_pre_os", os_inflight, 3);
        check_model();
        tick();
        apply(1, 10'h001, 0, 0);
        check("midrst_req_ready", req_ready, '0);
        check_model();
        tick();
        apply(0, '0, 1, 0);
        check("midrst_valid", arb_req_valid, 1'b0);
        check("midrst_os", os_inflight, 0);
        check_model();
        tick();

`ifdef NV_NVDLA_XVIF_RD_IG_STALL_STAT_EN
        // Limit 0: one grant, then 7 cycles of os-blocked requesting.
        set_cfg(0, 0);
        step(1, '0, 1, 0);
        step(0, 10'h010, 1, 0);
        for (int c = 0; c < 7; c++) begin
            apply(0, 10'h010, 1, 0);
            check("stat_req_ready", req_ready, '0);
            check_model();
            tick();
        end
        apply(0, '0, 1, 0);
        check("stat_os_stall_cnt", os_stall_cnt, 7);
        check_model();
        tick();
`endif

        // Randomized traffic with quasi-static weights and an occasionally moved limit.
        for (int i = 0; i < N; i++) weight[i] = $urandom_range(0, 3);
        for (int i = 0; i < N; i++) reg2dp_rd_weight[i*WT_W +: WT_W] = WT_W'(weight[i]);
        step(1, '0, 1, 0);
        for (int c = 0; c < 800; c++) begin
            logic [31:0] rv;
            if (c % 60 == 0) begin
                os_lim = $urandom_range(0, 6);
                reg2dp_rd_os_cnt = OS_W'(os_lim);
            end
            rv = $urandom();
            step($urandom_range(0, 149) == 0, rv[N-1:0] & rv[N+9:10] | rv[N+19:20] & rv[N+9:10],
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
